spi_slave_shift: RTL

//  SPI target-side (slave) shift engine: the responder to spi_flash_shift on the same SPI bus.

---
 rtl/spi_slave_shift.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_shift.sv
// spi_slave_shift -- SPI target-side shift engine, responder to spi_flash_shift.
//
// sclk, ss_n and mosi are oversampled in the clk domain. One character of
// 1..MAX_CHAR bits is shifted in on mosi while one is shifted out on miso.
// The host side sees a single-entry tx buffer and a right-justified rx word
// with a one-cycle valid pulse.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   len, lsb          character length (0 = MAX_CHAR) and bit order, latched at word start
//   cpol, cpha        SPI mode; change only while idle
//   tx_data, tx_load  parallel tx word and its write strobe (taken only when tx_ready)
//   tx_ready          tx buffer empty
//   rx_data, rx_valid last received word and its one-cycle update pulse
//   underrun          one-cycle pulse: a word started with the tx buffer empty
//   abort             one-cycle pulse: ss_n deasserted mid-word
//   busy              synchronised ss_n asserted
//   ss_n, sclk, mosi  SPI line inputs (asynchronous to clk)
//   miso, miso_oe     SPI data out and its output enable (= busy)
module spi_slave_shift #(
    parameter int Tp       = 1,
    parameter int MAX_CHAR = 32,
    parameter int LEN_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_BITS-1:0] len,
    input  logic                lsb,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                rx_valid,
    output logic                underrun,
    output logic                abort,
    output logic                busy,
    input  logic                ss_n,
    input  logic                sclk,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe
);

    localparam int CW = LEN_BITS + 1;

    // Tp only exists so this block drops into benches written for
    // spi_flash_shift; the RTL itself carries no delays.
    if (Tp < 0 || MAX_CHAR < 2 || MAX_CHAR > (1 << LEN_BITS)) begin : g_param_check
        $error("spi_slave_shift: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_nxt;

    // ---------------- synchronisers ----------------
    logic [2:0] sclk_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic ss_s, ss_fall, mosi_s, sclk_edge, lead_edge, trail_edge;
    logic sample_edge, drive_edge;

    assign ss_s        = ss_q[1];
    assign ss_fall     = ss_q[2] & ~ss_q[1];
    assign mosi_s      = mosi_q[1];
    assign sclk_edge   = sclk_q[1] ^ sclk_q[2];
    assign lead_edge   = sclk_edge & (sclk_q[2] == cpol);
    assign trail_edge  = sclk_edge & (sclk_q[1] == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign drive_edge  = cpha ? lead_edge  : trail_edge;

    // ---------------- datapath declarations ----------------
    logic [CW-1:0]       cnt, bits_q, bits_w;
    logic [MAX_CHAR-1:0] tx_buf, tx_sr, tx_word, tx_init;
    logic [MAX_CHAR-1:0] rx_sr, rx_shift, rx_word;
    logic                load_en, sample_en, drive_en, word_done, abort_det;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (state != IDLE && ss_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) state_nxt = LOAD;
                LOAD:    state_nxt = SHIFT;
                SHIFT:   if (word_done) state_nxt = LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // cnt == bits_q means no bit of the current word has been sampled yet.
    // Suppressing drives then skips the cpha=1 first leading edge (bit 0 is
    // already out from LOAD) and, for cpha=0, the trailing edge of the
    // previous word's last bit that lands after a back-to-back LOAD.
    always_comb begin
        load_en   = (state == LOAD) && !ss_s;
        sample_en = (state == SHIFT) && !ss_s && sample_edge && (cnt != '0);
        drive_en  = (state == SHIFT) && !ss_s && drive_edge && (cnt != bits_q);
        word_done = sample_en && (cnt == CW'(1));
        abort_det = (state == SHIFT) && ss_s && (cnt != bits_q);
    end

    // ---------------- datapath ----------------
    assign busy    = ~ss_s;
    assign miso_oe = busy;

    assign bits_w  = (len == '0) ? CW'(MAX_CHAR) : {1'b0, len};
    assign tx_word = tx_ready ? '0 : tx_buf;
    // MSB-first words are left-aligned so the next bit is always the top bit.
    assign tx_init = lsb ? tx_word : (tx_word << (CW'(MAX_CHAR) - bits_w));

    assign rx_shift = lsb ? {mosi_s, rx_sr[MAX_CHAR-1:1]} : {rx_sr[MAX_CHAR-2:0], mosi_s};
    // LSB-first bits enter at the top; right-justify once the word is complete.
    assign rx_word  = lsb ? (rx_shift >> (CW'(MAX_CHAR) - bits_q)) : rx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            miso     <= 1'b0;
            cnt      <= '0;
            bits_q   <= '0;
        end else begin
            rx_valid <= word_done;
            underrun <= load_en & tx_ready;
            abort    <= abort_det;

            if (load_en) begin
                bits_q   <= bits_w;
                cnt      <= bits_w;
                rx_sr    <= '0;
                tx_sr    <= tx_init;
                miso     <= lsb ? tx_init[0] : tx_init[MAX_CHAR-1];
                tx_ready <= 1'b1;
            end else begin
                if (sample_en) begin
                    cnt   <= cnt - CW'(1);
                    rx_sr <= rx_shift;
                    if (word_done) rx_data <= rx_word;
                end
                if (drive_en) begin
                    tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
                    miso  <= lsb ? tx_sr[1] : tx_sr[MAX_CHAR-2];
                end
            end

            // Placed after LOAD so a same-cycle write stays buffered while
            // LOAD takes the previous contents.
            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule
